// File: rtl/lstm_input_seq_pkg.sv
// Shared definitions for the LSTM input-ROM sequencer: FSM state encodings.
package lstm_input_seq_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StPresent = 2'd2,
    StDone    = 2'd3
  } state_e;

endpackage

// File: rtl/lstm_input_seq_if.sv
// Valid/ready stream carrying one input vector plus timestep tags to the LSTM cell.
interface lstm_input_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NUM   = 3
);
  logic [NUM*WIDTH-1:0] x_data;
  logic                 x_valid;
  logic                 x_ready;
  logic                 x_first;
  logic                 x_last;
  logic [WIDTH-1:0]     step;

  modport master (
    output x_data, x_valid, x_first, x_last, step,
    input  x_ready
  );

  modport slave (
    input  x_data, x_valid, x_first, x_last, step,
    output x_ready
  );
endinterface

// File: rtl/lstm_input_seq_step_counter.sv
// Timestep counter with synchronous clear/increment and a terminal flag at the last timestep.
module lstm_input_seq_step_counter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NUM_ITERATIONS = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] step_o,
  output logic             last_o
);

  logic [WIDTH-1:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (clr_i) begin
      step_d = '0;
    end else if (inc_i) begin
      step_d = step_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;
  assign last_o = (step_q == WIDTH'(NUM_ITERATIONS - 1));

endmodule

// File: rtl/lstm_input_seq.sv
// Walks one stored input sequence through the ROM address port and streams each
// registered vector to the LSTM cell, tagging the first and last timestep.
module lstm_input_seq
  import lstm_input_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NUM            = 3,
  parameter int unsigned NUM_ITERATIONS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     seq_sel,
  input  logic                 abort,
  output logic [WIDTH-1:0]     mem_addr,
  input  logic [NUM*WIDTH-1:0] mem_data,
  lstm_input_seq_if.master     x_if,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [NUM*WIDTH-1:0] x_data_q, x_data_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0] step;
  logic             step_last;
  logic             start_ok;
  logic             xfer;
  logic [WIDTH-1:0] load_addr;

  assign start_ok  = start && (seq_sel < WIDTH'(NUM));
  assign xfer      = (state_q == StPresent) && x_if.x_ready;
  assign load_addr = base_q + step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_ok) state_d = StLoad;
      StLoad:    state_d = StPresent;
      StPresent: if (xfer) state_d = step_last ? StDone : StLoad;
      StDone:    state_d = StIdle;
    endcase
    // Abort wins over everything, including a transfer in the same cycle.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    base_d   = base_q;
    addr_d   = addr_q;
    x_data_d = x_data_q;
    err_d    = (state_q == StIdle) && start && !start_ok;
    if ((state_q == StIdle) && start_ok) begin
      base_d = seq_sel * WIDTH'(NUM_ITERATIONS);
    end
    if (state_q == StLoad) begin
      addr_d   = load_addr;
      x_data_d = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q   <= '0;
      addr_q   <= '0;
      x_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      base_q   <= base_d;
      addr_q   <= addr_d;
      x_data_q <= x_data_d;
      err_q    <= err_d;
    end
  end

  lstm_input_seq_step_counter #(
    .WIDTH          (WIDTH),
    .NUM_ITERATIONS (NUM_ITERATIONS)
  ) u_step_counter (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  ((state_q == StIdle) && start_ok),
    .inc_i  (xfer && !step_last && !abort),
    .step_o (step),
    .last_o (step_last)
  );

  // ROM is read combinationally, so LOAD presents the live address; elsewhere it holds.
  always_comb begin
    mem_addr       = (state_q == StLoad) ? load_addr : addr_q;
    x_if.x_data    = x_data_q;
    x_if.x_valid   = (state_q == StPresent);
    x_if.x_first   = (state_q == StPresent) && (step == '0);
    x_if.x_last    = (state_q == StPresent) && step_last;
    x_if.step      = step;
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
    err            = err_q;
  end

endmodule

// File: tb/tb_lstm_input_seq.sv
// Directed bench for lstm_input_seq with a ROM model where word k holds k in every element.
module tb_lstm_input_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NUM   = 3;
  localparam int unsigned NI    = 5;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [WIDTH-1:0]     seq_sel;
  logic                 abort;
  logic [WIDTH-1:0]     mem_addr;
  logic [NUM*WIDTH-1:0] mem_data;
  logic                 busy;
  logic                 done;
  logic                 err;

  int errors = 0;
  int checks = 0;

  lstm_input_seq_if #(.WIDTH(WIDTH), .NUM(NUM)) x_if ();

  lstm_input_seq #(
    .WIDTH          (WIDTH),
    .NUM            (NUM),
    .NUM_ITERATIONS (NI)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seq_sel  (seq_sel),
    .abort    (abort),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .x_if     (x_if),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  assign mem_data = {NUM{mem_addr}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM*WIDTH-1:0] word(input int k);
    logic [WIDTH-1:0] w;
    w = WIDTH'(k);
    return {NUM{w}};
  endfunction

  task automatic chk(input string tag, input logic [NUM*WIDTH-1:0] obs,
                     input logic [NUM*WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"},  mem_addr, '0);
    chk({tag, "_data"},  x_if.x_data, '0);
    chk({tag, "_valid"}, x_if.x_valid, '0);
    chk({tag, "_first"}, x_if.x_first, '0);
    chk({tag, "_last"},  x_if.x_last, '0);
    chk({tag, "_step"},  x_if.step, '0);
    chk({tag, "_busy"},  busy, '0);
    chk({tag, "_done"},  done, '0);
    chk({tag, "_err"},   err, '0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; seq_sel = '0; abort = 1'b0; x_if.x_ready = 1'b0;
    cyc(); cyc();
    chk_zero("reset");
    rst = 1'b1;
    cyc();

    // Sequence 1 with ready high; a second start mid-run must be ignored.
    x_if.x_ready = 1'b1; start = 1'b1; seq_sel = 1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start = 1'b0; seq_sel = 1;
      chk("s1_addr", mem_addr, 96'(5 + k));
      chk("s1_busy", busy, 1);
      chk("s1_valid_load", x_if.x_valid, 0);
      if (k == 3) chk("s1_err_ignored", err, 0);
      cyc();
      chk("s1_valid", x_if.x_valid, 1);
      chk("s1_data", x_if.x_data, word(5 + k));
      chk("s1_first", x_if.x_first, 96'(k == 0));
      chk("s1_last", x_if.x_last, 96'(k == NI - 1));
      chk("s1_step", x_if.step, 96'(k));
      if (k == 2) begin
        start = 1'b1; seq_sel = 0;
      end
      cyc();
    end
    start = 1'b0;
    chk("s1_done", done, 1);
    chk("s1_done_busy", busy, 1);
    chk("s1_done_valid", x_if.x_valid, 0);
    cyc();
    chk("s1_idle_done", done, 0);
    chk("s1_idle_busy", busy, 0);
    chk("s1_addr_hold", mem_addr, 96'(9));

    // Sequence 0 with a 3-cycle stall at step 2.
    start = 1'b1; seq_sel = 0;
    cyc();
    start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("s2_addr", mem_addr, 96'(k));
      cyc();
      if (k == 2) begin
        x_if.x_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          cyc();
          chk("s2_stall_valid", x_if.x_valid, 1);
          chk("s2_stall_data", x_if.x_data, word(2));
          chk("s2_stall_step", x_if.step, 96'(2));
        end
        x_if.x_ready = 1'b1;
      end
      chk("s2_valid", x_if.x_valid, 1);
      chk("s2_data", x_if.x_data, word(k));
      cyc();
    end
    chk("s2_done", done, 1);
    cyc();

    // Illegal sequence index.
    start = 1'b1; seq_sel = 3;
    cyc();
    start = 1'b0;
    chk("s3_err", err, 1);
    chk("s3_busy", busy, 0);
    chk("s3_addr", mem_addr, 96'(4));
    chk("s3_valid", x_if.x_valid, 0);
    cyc();
    chk("s3_err_once", err, 0);
    chk("s3_busy_after", busy, 0);

    // Abort coinciding with the transfer at step 3 of sequence 2.
    start = 1'b1; seq_sel = 2;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("s4_addr", mem_addr, 96'(10 + k));
      cyc();
      chk("s4_data", x_if.x_data, word(10 + k));
      if (k == 3) abort = 1'b1;
      cyc();
    end
    abort = 1'b0;
    chk("s4_abort_busy", busy, 0);
    chk("s4_abort_valid", x_if.x_valid, 0);
    chk("s4_abort_done", done, 0);
    cyc();
    chk("s4_no_done", done, 0);
    start = 1'b1; seq_sel = 0;
    cyc();
    start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("s4_rerun_addr", mem_addr, 96'(k));
      cyc();
      chk("s4_rerun_data", x_if.x_data, word(k));
      chk("s4_rerun_first", x_if.x_first, 96'(k == 0));
      cyc();
    end
    chk("s4_rerun_done", done, 1);
    cyc();

    // Asynchronous reset during PRESENT.
    start = 1'b1; seq_sel = 1;
    cyc();
    start = 1'b0;
    cyc();
    chk("s6_valid_before", x_if.x_valid, 1);
    #2 rst = 1'b0;
    #1 chk_zero("s6_async");
    cyc();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("s6_post_busy", busy, 0);
      chk("s6_post_addr", mem_addr, '0);
      chk("s6_post_valid", x_if.x_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
